// File: rtl/sobel_param_obf.sv
// Key-locked Sobel edge filter with generic frame size and pixel width.
// Reads a greyscale frame through a 1-cycle-latency RAM port, computes the
// clamped Sobel magnitude per interior pixel and writes one value per location.
// A wrong key adds one extra cycle per interior pixel and XOR-corrupts every output.

module sobel_param_obf #(
  parameter int                IMG_W       = 512,
  parameter int                IMG_H       = 512,
  parameter int                PIX_W       = 8,
  parameter int                ADDR_W      = 18,
  parameter int                KEY_W       = 8,
  parameter logic [KEY_W-1:0]  CORRECT_KEY = 8'hA5
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  thresh,
  input  logic [KEY_W-1:0]  working_key,
  output logic [ADDR_W-1:0] indata_address0,
  output logic              indata_ce0,
  input  logic [PIX_W-1:0]  indata_q0,
  output logic [ADDR_W-1:0] outdata_address0,
  output logic              outdata_ce0,
  output logic              outdata_we0,
  output logic [PIX_W-1:0]  outdata_d0
);

  localparam int                AW     = PIX_W + 4;
  localparam logic [PIX_W-1:0]  MAXV   = {PIX_W{1'b1}};
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ACC   = 3'd2,
    S_DUMMY = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // ---------------------------------------------------------------- helpers
  function automatic logic is_border(input logic [ADDR_W-1:0] x,
                                     input logic [ADDR_W-1:0] y);
    return (x == ADDR_W'(0)) || (x == X_LAST) || (y == ADDR_W'(0)) || (y == Y_LAST);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] x,
                                                 input logic [ADDR_W-1:0] y);
    return y * W_A + x;
  endfunction

  // Tap (row,col) in 0..2 maps to neighbour (x+col-1, y+row-1); only used on
  // interior pixels so the modular arithmetic never wraps.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] x,
                                                 input logic [ADDR_W-1:0] y,
                                                 input logic [1:0]        row,
                                                 input logic [1:0]        col);
    return (y + ADDR_W'(row) - ADDR_W'(1)) * W_A + x + ADDR_W'(col) - ADDR_W'(1);
  endfunction

  // GX = [-1 0 1; -2 0 2; -1 0 1]
  function automatic logic signed [AW-1:0] coef_x(input logic [1:0] row,
                                                  input logic [1:0] col);
    logic signed [AW-1:0] w;
    w = (row == 2'd1) ? AW'(2) : AW'(1);
    if (col == 2'd0)      return -w;
    else if (col == 2'd2) return w;
    else                  return AW'(0);
  endfunction

  // GY = [-1 -2 -1; 0 0 0; 1 2 1]
  function automatic logic signed [AW-1:0] coef_y(input logic [1:0] row,
                                                  input logic [1:0] col);
    logic signed [AW-1:0] w;
    w = (col == 2'd1) ? AW'(2) : AW'(1);
    if (row == 2'd0)      return -w;
    else if (row == 2'd2) return w;
    else                  return AW'(0);
  endfunction

  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [AW-1:0] g);
    if (g[AW-1])                    return PIX_W'(0);
    else if (g > $signed(AW'(MAXV))) return MAXV;
    else                            return g[PIX_W-1:0];
  endfunction

  // Final pixel value from accumulators, sampled mode/threshold and lock mask.
  function automatic logic [PIX_W-1:0] pix_result(input logic [1:0]           md,
                                                  input logic [PIX_W-1:0]     th,
                                                  input logic                 kok,
                                                  input logic [PIX_W-1:0]     msk,
                                                  input logic signed [AW-1:0] gx,
                                                  input logic signed [AW-1:0] gy,
                                                  input logic                 border);
    logic [PIX_W-1:0] cx;
    logic [PIX_W-1:0] cy;
    logic [PIX_W-1:0] mag;
    logic [PIX_W-1:0] r;
    logic [PIX_W:0]   sum;
    cx  = clamp_pix(gx);
    cy  = clamp_pix(gy);
    sum = {1'b0, cx} + {1'b0, cy};
    mag = sum[PIX_W] ? MAXV : sum[PIX_W-1:0];
    if (border) begin
      r = ((md == 2'd1) || (md == 2'd2)) ? PIX_W'(0) : MAXV;
    end else begin
      case (md)
        2'd1:    r = mag;
        2'd2:    r = (mag >= th) ? MAXV : PIX_W'(0);
        default: r = ~mag;
      endcase
    end
    if (!kok) r = r ^ msk;
    else      r = r;
    return r;
  endfunction

  // ---------------------------------------------------------------- state
  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    x_q, x_d, y_q, y_d;
  logic [1:0]           row_q, row_d, col_q, col_d;
  logic signed [AW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [1:0]           mode_q, mode_d;
  logic [PIX_W-1:0]     thresh_q, thresh_d;
  logic                 key_ok_q, key_ok_d;
  logic [PIX_W-1:0]     mask_q, mask_d;
  logic                 ce_q, ce_d, we_q, we_d, done_q, done_d;
  logic [ADDR_W-1:0]    in_addr_q, in_addr_d, out_addr_q, out_addr_d;
  logic [PIX_W-1:0]     dout_q, dout_d;

  logic signed [AW-1:0] q_s;
  logic [PIX_W-1:0]     key_diff_s;

  assign q_s        = $signed({4'b0000, indata_q0});
  assign key_diff_s = PIX_W'(working_key ^ CORRECT_KEY);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_d      = row_q;
    col_d      = col_q;
    gx_d       = gx_q;
    gy_d       = gy_q;
    mode_d     = mode_q;
    thresh_d   = thresh_q;
    key_ok_d   = key_ok_q;
    mask_d     = mask_q;
    ce_d       = 1'b0;
    we_d       = 1'b0;
    done_d     = 1'b0;
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;
    dout_d     = dout_q;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          mode_d     = mode;
          thresh_d   = thresh;
          key_ok_d   = (working_key == CORRECT_KEY);
          mask_d     = (key_diff_s == PIX_W'(0)) ? PIX_W'(1) : key_diff_s;
          x_d        = ADDR_W'(0);
          y_d        = ADDR_W'(0);
          // Pixel (0,0) is always a border pixel.
          state_d    = S_WRITE;
          we_d       = 1'b1;
          out_addr_d = ADDR_W'(0);
          dout_d     = pix_result(mode_d, thresh_d, key_ok_d, mask_d, gx_q, gy_q, 1'b1);
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        state_d = S_ACC;
      end

      S_ACC: begin
        gx_d = gx_q + q_s * coef_x(row_q, col_q);
        gy_d = gy_q + q_s * coef_y(row_q, col_q);
        if ((row_q == 2'd2) && (col_q == 2'd2)) begin
          row_d = 2'd0;
          col_d = 2'd0;
          if (!key_ok_q) begin
            state_d = S_DUMMY;
          end else begin
            state_d    = S_WRITE;
            we_d       = 1'b1;
            out_addr_d = pix_addr(x_q, y_q);
            dout_d     = pix_result(mode_q, thresh_q, key_ok_q, mask_q, gx_d, gy_d, 1'b0);
          end
        end else begin
          if (col_q == 2'd2) begin
            col_d = 2'd0;
            row_d = row_q + 2'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
          state_d   = S_ISSUE;
          ce_d      = 1'b1;
          in_addr_d = tap_addr(x_q, y_q, row_d, col_d);
        end
      end

      S_DUMMY: begin
        state_d    = S_WRITE;
        we_d       = 1'b1;
        out_addr_d = pix_addr(x_q, y_q);
        dout_d     = pix_result(mode_q, thresh_q, key_ok_q, mask_q, gx_q, gy_q, 1'b0);
      end

      S_WRITE: begin
        if (x_q == X_LAST) begin
          x_d = ADDR_W'(0);
          y_d = y_q + ADDR_W'(1);
        end else begin
          x_d = x_q + ADDR_W'(1);
        end
        if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          x_d     = ADDR_W'(0);
          y_d     = ADDR_W'(0);
        end else if (!is_border(x_d, y_d)) begin
          state_d   = S_ISSUE;
          ce_d      = 1'b1;
          gx_d      = AW'(0);
          gy_d      = AW'(0);
          row_d     = 2'd0;
          col_d     = 2'd0;
          in_addr_d = tap_addr(x_d, y_d, 2'd0, 2'd0);
        end else begin
          state_d    = S_WRITE;
          we_d       = 1'b1;
          out_addr_d = pix_addr(x_d, y_d);
          dout_d     = pix_result(mode_q, thresh_q, key_ok_q, mask_q, gx_q, gy_q, 1'b1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset aborts any frame in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= ADDR_W'(0);
      y_q        <= ADDR_W'(0);
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      gx_q       <= AW'(0);
      gy_q       <= AW'(0);
      mode_q     <= 2'd0;
      thresh_q   <= PIX_W'(0);
      key_ok_q   <= 1'b0;
      mask_q     <= PIX_W'(0);
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      in_addr_q  <= ADDR_W'(0);
      out_addr_q <= ADDR_W'(0);
      dout_q     <= PIX_W'(0);
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_q      <= row_d;
      col_q      <= col_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      mode_q     <= mode_d;
      thresh_q   <= thresh_d;
      key_ok_q   <= key_ok_d;
      mask_q     <= mask_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      done_q     <= done_d;
      in_addr_q  <= in_addr_d;
      out_addr_q <= out_addr_d;
      dout_q     <= dout_d;
    end
  end

  assign ap_done          = done_q;
  assign ap_ready         = done_q;
  assign ap_idle          = (state_q == S_IDLE) && !ap_start;
  assign indata_ce0       = ce_q;
  assign indata_address0  = in_addr_q;
  assign outdata_ce0      = we_q;
  assign outdata_we0      = we_q;
  assign outdata_address0 = out_addr_q;
  assign outdata_d0       = dout_q;

endmodule

// File: tb/tb_sobel_param_obf.sv
// Self-checking bench for sobel_param_obf on a 4x4 frame: behavioural Sobel
// model, per-cycle compare process, literal anchor values and randomized frames.

module tb_sobel_param_obf;

  localparam int         W    = 4;
  localparam int         H    = 4;
  localparam int         NPIX = W * H;
  localparam int         NI   = (W - 2) * (H - 2);
  localparam int         NB   = NPIX - NI;
  localparam logic [7:0] CK   = 8'hA5;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_done, ap_idle, ap_ready;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  thresh = 8'd0;
  logic [7:0]  working_key = CK;
  logic [17:0] indata_address0;
  logic        indata_ce0;
  logic [7:0]  indata_q0 = 8'd0;
  logic [17:0] outdata_address0;
  logic        outdata_ce0, outdata_we0;
  logic [7:0]  outdata_d0;

  sobel_param_obf #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(18), .KEY_W(8), .CORRECT_KEY(CK)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .mode(mode), .thresh(thresh), .working_key(working_key),
    .indata_address0(indata_address0), .indata_ce0(indata_ce0), .indata_q0(indata_q0),
    .outdata_address0(outdata_address0), .outdata_ce0(outdata_ce0),
    .outdata_we0(outdata_we0), .outdata_d0(outdata_d0)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int total_we = 0;
  logic [7:0] img [0:NPIX-1];
  int exp_px [0:NPIX-1];
  int out_cap [0:NPIX-1];
  int rd_q [$];
  int wr_next, nwrites, nreads;
  bit active = 1'b0;
  int m_mode, m_thresh, m_key;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Input RAM with one cycle read latency.
  always @(posedge ap_clk) begin
    if (indata_ce0) begin
      if (int'(indata_address0) < NPIX) indata_q0 <= img[int'(indata_address0)];
      else                              indata_q0 <= 8'h00;
    end
  end

  always @(posedge ap_clk) cyc <= cyc + 1;
  always @(posedge ap_clk) if (outdata_we0) total_we <= total_we + 1;

  // ---------------------------------------------------------------- model
  function automatic int p(input int x, input int y);
    return int'(img[y * W + x]);
  endfunction

  function automatic int model_px(input int x, input int y);
    int gx, gy, cx, cy, mag, r, m;
    if (x == 0 || y == 0 || x == W - 1 || y == H - 1) begin
      r = (m_mode == 1 || m_mode == 2) ? 0 : 255;
    end else begin
      gx = (p(x+1, y-1) + 2 * p(x+1, y) + p(x+1, y+1))
         - (p(x-1, y-1) + 2 * p(x-1, y) + p(x-1, y+1));
      gy = (p(x-1, y+1) + 2 * p(x, y+1) + p(x+1, y+1))
         - (p(x-1, y-1) + 2 * p(x, y-1) + p(x+1, y-1));
      cx  = (gx < 0) ? 0 : ((gx > 255) ? 255 : gx);
      cy  = (gy < 0) ? 0 : ((gy > 255) ? 255 : gy);
      mag = (cx + cy > 255) ? 255 : cx + cy;
      if (m_mode == 1)      r = mag;
      else if (m_mode == 2) r = (mag >= m_thresh) ? 255 : 0;
      else                  r = 255 - mag;
    end
    if (m_key != int'(CK)) begin
      m = (m_key ^ int'(CK)) & 255;
      if (m == 0) m = 1;
      r = r ^ m;
    end
    return r;
  endfunction

  task automatic build_model();
    rd_q.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        exp_px[y * W + x]  = model_px(x, y);
        out_cap[y * W + x] = -1;
        if (x > 0 && y > 0 && x < W - 1 && y < H - 1) begin
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              rd_q.push_back((y + dy) * W + (x + dx));
        end
      end
    end
    wr_next = 0;
    nwrites = 0;
    nreads  = 0;
  endtask

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge ap_clk) begin
    if (ap_rst_n && active) begin
      chk("ready_eq_done", int'(ap_ready), int'(ap_done));
      chk("rd_wr_overlap", int'(indata_ce0 & outdata_we0), 0);
      if (outdata_we0) begin
        nwrites++;
        chk("wr_ce", int'(outdata_ce0), 1);
        if (wr_next >= NPIX) begin
          chk("wr_extra", int'(outdata_address0), -1);
        end else begin
          chk("wr_addr", int'(outdata_address0), wr_next);
          chk("wr_data", int'(outdata_d0), exp_px[wr_next]);
          out_cap[wr_next] = int'(outdata_d0);
        end
        wr_next++;
      end
      if (indata_ce0) begin
        nreads++;
        if (rd_q.size() == 0) chk("rd_extra", int'(indata_address0), -1);
        else                  chk("rd_addr", int'(indata_address0), rd_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic run_frame(input int md, input int th, input int key, input bit pulses,
                           input int abort_at, output int lat);
    int st;
    m_mode   = (md == 3) ? 0 : md;
    m_thresh = th;
    m_key    = key;
    build_model();
    @(negedge ap_clk);
    mode        = 2'(md);
    thresh      = 8'(th);
    working_key = 8'(key);
    ap_start    = 1'b1;
    active      = 1'b1;
    st          = cyc;
    lat         = 0;
    forever begin
      @(negedge ap_clk);
      lat = cyc - st;
      if (ap_done) break;
      if (abort_at > 0 && lat == abort_at) break;
      if (lat > 3000) begin
        chk("done_timeout", lat, -1);
        break;
      end
      ap_start    = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
      mode        = 2'($urandom_range(0, 3));
      thresh      = 8'($urandom);
      working_key = 8'($urandom);
    end
    ap_start = 1'b0;
  endtask

  task automatic frame_checks(input int key, input int lat);
    int exp_lat;
    exp_lat = NB + 19 * NI + 1 + ((key != int'(CK)) ? NI : 0);
    chk("latency", lat, exp_lat);
    chk("done_pulse", int'(ap_done), 1);
    repeat (3) @(negedge ap_clk);
    chk("done_one_cycle", int'(ap_done), 0);
    chk("idle_after", int'(ap_idle), 1);
    chk("writes", nwrites, NPIX);
    chk("reads", nreads, 9 * NI);
    chk("reads_left", rd_q.size(), 0);
  endtask

  task automatic load_flat(input int v);
    for (int i = 0; i < NPIX; i++) img[i] = 8'(v);
  endtask

  task automatic load_edge();
    for (int i = 0; i < NPIX; i++) img[i] = ((i % W) >= 2) ? 8'd200 : 8'd0;
  endtask

  initial begin
    int lat, key, we_snap;
    // Reset state
    #1;
    chk("rst_done", int'(ap_done), 0);
    chk("rst_ready", int'(ap_ready), 0);
    chk("rst_ce", int'(indata_ce0), 0);
    chk("rst_we", int'(outdata_we0), 0);
    chk("rst_oce", int'(outdata_ce0), 0);
    chk("rst_iaddr", int'(indata_address0), 0);
    chk("rst_oaddr", int'(outdata_address0), 0);
    chk("rst_d0", int'(outdata_d0), 0);
    chk("rst_idle", int'(ap_idle), 1);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);

    // Flat frame, key ok, mode 0
    load_flat(100);
    run_frame(0, 0, int'(CK), 1'b0, 0, lat);
    chk("lit_flat_lat", lat, 89);
    chk("lit_flat_border", out_cap[0], 255);
    chk("lit_flat_interior", out_cap[5], 255);
    frame_checks(int'(CK), lat);

    // Flat frame, mode 2, thresh 0
    run_frame(2, 0, int'(CK), 1'b0, 0, lat);
    chk("lit_flat_m2", out_cap[6], 255);
    chk("lit_flat_m2_border", out_cap[3], 0);
    frame_checks(int'(CK), lat);

    // Vertical edge frame in modes 1, 0, 2
    load_edge();
    run_frame(1, 0, int'(CK), 1'b0, 0, lat);
    chk("lit_edge_m1_11", out_cap[5], 255);
    chk("lit_edge_m1_21", out_cap[6], 255);
    chk("lit_edge_m1_12", out_cap[9], 255);
    chk("lit_edge_m1_22", out_cap[10], 255);
    chk("lit_edge_m1_border", out_cap[15], 0);
    frame_checks(int'(CK), lat);
    run_frame(0, 0, int'(CK), 1'b0, 0, lat);
    chk("lit_edge_m0_int", out_cap[5], 0);
    chk("lit_edge_m0_border", out_cap[0], 255);
    frame_checks(int'(CK), lat);
    run_frame(2, 128, int'(CK), 1'b0, 0, lat);
    chk("lit_edge_m2_int", out_cap[10], 255);
    frame_checks(int'(CK), lat);

    // Locked key
    load_flat(100);
    run_frame(0, 0, 32'hA0, 1'b0, 0, lat);
    chk("lit_lock_lat", lat, 93);
    chk("lit_lock_border", out_cap[0], 250);
    chk("lit_lock_interior", out_cap[5], 250);
    chk("lit_lock_reads", nreads, 36);
    frame_checks(32'hA0, lat);

    // Asynchronous reset mid-frame
    run_frame(0, 0, int'(CK), 1'b0, 40, lat);
    active = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    chk("abort_ce", int'(indata_ce0), 0);
    chk("abort_we", int'(outdata_we0), 0);
    chk("abort_d0", int'(outdata_d0), 0);
    chk("abort_oaddr", int'(outdata_address0), 0);
    we_snap = total_we;
    repeat (4) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (8) @(negedge ap_clk);
    chk("abort_no_writes", total_we, we_snap);
    chk("abort_idle", int'(ap_idle), 1);

    // Restart with spurious start pulses during the frame
    run_frame(1, 0, int'(CK), 1'b1, 0, lat);
    frame_checks(int'(CK), lat);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
      key = ($urandom_range(0, 1) == 1) ? int'(CK) : int'($urandom_range(0, 255));
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), key, 1'b1, 0, lat);
      frame_checks(key, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
